// File: rtl/audio_pkg.sv
// Shared audio types and constants for the I2S transmit path.
package audio_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [2*SAMPLE_W-1:0]      frame_t;

endpackage : audio_pkg

// File: rtl/sample_fifo.sv
// Small synchronous sample FIFO. There is no bypass path, so a pushed sample
// can only be popped on a later cycle. A push while full is ignored unless a
// pop happens in the same cycle.
module sample_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == LVL_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem_q[rd_ptr_q];
    assign level   = count_q;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (reset_n && push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule : sample_fifo

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: buffers mono samples and sends each one on both channels.
// The frame runs continuously from the clock divider; a frame with no new
// sample repeats the last one and flags underrun.
module audio_i2s_tx #(
    parameter int SAMPLE_W   = audio_pkg::SAMPLE_W,
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          sample_valid,
    input  logic [SAMPLE_W-1:0]           sample,
    input  logic                          mute,
    output logic                          i2s_bclk,
    output logic                          i2s_lrck,
    output logic                          i2s_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic                          overflow
);

    localparam int DIV_W   = $clog2(BCLK_DIV);
    localparam int FRAME_W = 2 * SAMPLE_W;
    localparam int SLOT_W  = $clog2(FRAME_W);

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                bclk_q, bclk_d;
    logic                lrck_q, lrck_d;
    logic                data_q, data_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic [SAMPLE_W-1:0] last_q, last_d;
    logic                underrun_q, underrun_d;
    logic                overflow_q, overflow_d;

    logic                div_wrap, fall_edge, frame_start;
    logic                fifo_full, fifo_empty;
    logic [SAMPLE_W-1:0] fifo_head, src;

    assign div_wrap    = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
    assign fall_edge   = div_wrap & bclk_q;
    // slot_q holds the number of the slot that the next falling edge begins.
    assign frame_start = fall_edge & (slot_q == '0);

    sample_fifo #(
        .W     (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (sample_valid),
        .push_data (sample),
        .pop       (frame_start),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign src = fifo_empty ? last_q : fifo_head;

    // Divider, slot sequencing, serialiser and status pulses.
    always_comb begin
        div_cnt_d  = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
        bclk_d     = div_wrap ? ~bclk_q : bclk_q;
        lrck_d     = lrck_q;
        data_d     = data_q;
        slot_d     = slot_q;
        shift_d    = shift_q;
        last_d     = last_q;
        underrun_d = frame_start & fifo_empty;
        // A pop only happens at frame start when the FIFO holds data, which a
        // full FIFO always does, so frame_start alone frees a slot.
        overflow_d = sample_valid & fifo_full & ~frame_start;

        if (fall_edge) begin
            slot_d  = (slot_q == SLOT_W'(FRAME_W - 1)) ? '0 : slot_q + SLOT_W'(1);
            lrck_d  = (slot_q >= SLOT_W'(SAMPLE_W));
            // The MSB still in the shifter at slot 0 is last frame's right LSB,
            // which gives the one-bclk I2S delay without extra state.
            data_d  = shift_q[FRAME_W-1];
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
        end

        if (frame_start) begin
            if (!fifo_empty) last_d = fifo_head;
            shift_d = mute ? '0 : {src, src};
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_q  <= '0;
            bclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            data_q     <= 1'b0;
            slot_q     <= '0;
            shift_q    <= '0;
            last_q     <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bclk_q     <= bclk_d;
            lrck_q     <= lrck_d;
            data_q     <= data_d;
            slot_q     <= slot_d;
            shift_q    <= shift_d;
            last_q     <= last_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    assign i2s_bclk = bclk_q;
    assign i2s_lrck = lrck_q;
    assign i2s_data = data_q;
    assign underrun = underrun_q;
    assign overflow = overflow_q;

endmodule : audio_i2s_tx

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx at default parameters (frame = 256 clk).
// Inputs change and outputs are sampled on the falling clk edge.
module tb_audio_i2s_tx;
    import audio_pkg::*;

    logic    clk = 1'b0;
    logic    reset_n = 1'b0;
    logic    sample_valid = 1'b0;
    logic    mute = 1'b0;
    sample_t sample = '0;
    logic    i2s_bclk, i2s_lrck, i2s_data, underrun, overflow;
    logic [2:0] fifo_level;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    audio_i2s_tx #(
        .SAMPLE_W   (16),
        .BCLK_DIV   (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .mute         (mute),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_data     (i2s_data),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; slot k of any frame is visible when
    // (cyc-8) % 256 == 8*k.
    always @(posedge clk) cyc <= reset_n ? cyc + 1 : 0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; sample_valid = 1'b0; mute = 1'b0; sample = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_pos(input int m);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (cyc >= 8 && ((cyc - 8) % 256) == m) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            $display("FAIL wait_pos: frame position %0d not reached, cyc=%0d", m, cyc);
        end
    endtask

    task automatic wait_slot(input int k);
        wait_pos(8 * k);
    endtask

    task automatic push(input logic [15:0] v);
        sample_valid = 1'b1; sample = v;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic collect_frame(output logic [15:0] l, output logic [14:0] r);
        l = '0; r = '0;
        for (int k = 1; k <= 16; k++) begin
            wait_slot(k);
            l = {l[14:0], i2s_data};
        end
        for (int k = 17; k <= 31; k++) begin
            wait_slot(k);
            r = {r[13:0], i2s_data};
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (i2s_bclk !== 1'b0) $display("FAIL reset_bclk: got %b want 0", i2s_bclk); else passes++;
        checks++; if (i2s_lrck !== 1'b0) $display("FAIL reset_lrck: got %b want 0", i2s_lrck); else passes++;
        checks++; if (i2s_data !== 1'b0) $display("FAIL reset_data: got %b want 0", i2s_data); else passes++;
        checks++; if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else passes++;
        checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else passes++;
    endtask

    task automatic test_basic_frame();
        logic [31:0] w;
        logic        el;
        do_reset();
        push(16'h8001);
        w = 32'h8001_8001;
        wait_slot(0);
        checks++; if (i2s_data !== 1'b0) $display("FAIL basic_slot0_data: got %b want 0", i2s_data); else passes++;
        checks++; if (underrun !== 1'b0) $display("FAIL basic_slot0_underrun: got %b want 0", underrun); else passes++;
        checks++; if (fifo_level !== 3'd0) $display("FAIL basic_level: got %0d want 0", fifo_level); else passes++;
        for (int k = 1; k <= 31; k++) begin
            wait_slot(k);
            el = (k >= 16);
            checks++;
            if (i2s_data !== w[32-k]) $display("FAIL basic_data slot %0d: got %b want %b", k, i2s_data, w[32-k]);
            else passes++;
            checks++;
            if (i2s_lrck !== el) $display("FAIL basic_lrck slot %0d: got %b want %b", k, i2s_lrck, el);
            else passes++;
        end
        wait_slot(0);
        checks++; if (i2s_data !== 1'b1) $display("FAIL basic_next_slot0_data: got %b want 1", i2s_data); else passes++;
        checks++; if (i2s_lrck !== 1'b0) $display("FAIL basic_next_slot0_lrck: got %b want 0", i2s_lrck); else passes++;
        checks++; if (underrun !== 1'b1) $display("FAIL basic_next_underrun: got %b want 1", underrun); else passes++;
    endtask

    task automatic test_underrun();
        int          pulses;
        logic        eu, eb;
        logic [15:0] l;
        logic [14:0] r;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 530; i++) begin
            @(negedge clk);
            eu = (cyc >= 8) && (((cyc - 8) % 256) == 0);
            eb = 1'(((cyc / 4) % 2));
            if (underrun === 1'b1) pulses++;
            checks++;
            if (underrun !== eu) $display("FAIL idle_underrun cyc %0d: got %b want %b", cyc, underrun, eu);
            else passes++;
            checks++;
            if (i2s_bclk !== eb) $display("FAIL idle_bclk cyc %0d: got %b want %b", cyc, i2s_bclk, eb);
            else passes++;
            checks++;
            if (i2s_data !== 1'b0) $display("FAIL idle_data cyc %0d: got %b want 0", cyc, i2s_data);
            else passes++;
        end
        checks++; if (pulses != 3) $display("FAIL idle_pulse_count: got %0d want 3", pulses); else passes++;
        push(16'h1234);
        wait_slot(0);
        checks++; if (underrun !== 1'b0) $display("FAIL u1234_first_underrun: got %b want 0", underrun); else passes++;
        collect_frame(l, r);
        checks++; if (l !== 16'h1234) $display("FAIL u1234_left: got %h want 1234", l); else passes++;
        checks++; if (r !== 15'h091A) $display("FAIL u1234_right: got %h want 091a", r); else passes++;
        wait_slot(0);
        checks++; if (i2s_data !== 1'b0) $display("FAIL u1234_lsb: got %b want 0", i2s_data); else passes++;
        checks++; if (underrun !== 1'b1) $display("FAIL u1234_repeat_underrun: got %b want 1", underrun); else passes++;
        collect_frame(l, r);
        checks++; if (l !== 16'h1234) $display("FAIL u1234_repeat_left: got %h want 1234", l); else passes++;
    endtask

    task automatic test_overflow();
        logic [15:0] l;
        logic [14:0] r;
        int          el;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            sample_valid = 1'b1; sample = 16'(i);
            @(negedge clk);
            el = (i < 4) ? i : 4;
            checks++;
            if (overflow !== (i == 5)) $display("FAIL ovf_pulse push %0d: got %b want %b", i, overflow, (i == 5));
            else passes++;
            checks++;
            if (fifo_level !== 3'(el)) $display("FAIL ovf_level push %0d: got %0d want %0d", i, fifo_level, el);
            else passes++;
        end
        sample_valid = 1'b0;
        for (int f = 1; f <= 4; f++) begin
            collect_frame(l, r);
            checks++;
            if (l !== 16'(f)) $display("FAIL ovf_frame_left %0d: got %h want %h", f, l, 16'(f));
            else passes++;
            checks++;
            if (r !== 15'(f >> 1)) $display("FAIL ovf_frame_right %0d: got %h want %h", f, r, 15'(f >> 1));
            else passes++;
        end
        checks++; if (fifo_level !== 3'd0) $display("FAIL ovf_drained: got %0d want 0", fifo_level); else passes++;
    endtask

    task automatic test_reset_midframe();
        int first;
        do_reset();
        push(16'hB001);
        push(16'hB002);
        wait_slot(20);
        checks++; if (fifo_level !== 3'd1) $display("FAIL mid_level_before: got %0d want 1", fifo_level); else passes++;
        checks++; if (i2s_lrck !== 1'b1) $display("FAIL mid_lrck_before: got %b want 1", i2s_lrck); else passes++;
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (i2s_bclk !== 1'b0) $display("FAIL mid_bclk: got %b want 0", i2s_bclk); else passes++;
        checks++; if (i2s_lrck !== 1'b0) $display("FAIL mid_lrck: got %b want 0", i2s_lrck); else passes++;
        checks++; if (i2s_data !== 1'b0) $display("FAIL mid_data: got %b want 0", i2s_data); else passes++;
        checks++; if (fifo_level !== 3'd0) $display("FAIL mid_level: got %0d want 0", fifo_level); else passes++;
        reset_n = 1'b1;
        first = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (underrun === 1'b1 && first == 0) first = n;
        end
        checks++; if (first != 8) $display("FAIL mid_first_slot0: got cycle %0d want 8", first); else passes++;
    endtask

    task automatic test_mute();
        logic [15:0] l;
        logic [14:0] r;
        do_reset();
        mute = 1'b1;
        push(16'h7FFF);
        checks++; if (fifo_level !== 3'd1) $display("FAIL mute_level_before: got %0d want 1", fifo_level); else passes++;
        wait_slot(0);
        checks++; if (fifo_level !== 3'd0) $display("FAIL mute_level_after: got %0d want 0", fifo_level); else passes++;
        checks++; if (underrun !== 1'b0) $display("FAIL mute_underrun: got %b want 0", underrun); else passes++;
        collect_frame(l, r);
        checks++; if (l !== 16'h0000) $display("FAIL mute_left: got %h want 0000", l); else passes++;
        checks++; if (r !== 15'h0000) $display("FAIL mute_right: got %h want 0000", r); else passes++;
        mute = 1'b0;
        wait_slot(0);
        checks++; if (underrun !== 1'b1) $display("FAIL unmute_underrun: got %b want 1", underrun); else passes++;
        checks++; if (i2s_data !== 1'b0) $display("FAIL unmute_slot0: got %b want 0", i2s_data); else passes++;
        collect_frame(l, r);
        checks++; if (l !== 16'h7FFF) $display("FAIL unmute_left: got %h want 7fff", l); else passes++;
        checks++; if (r !== 15'h3FFF) $display("FAIL unmute_right: got %h want 3fff", r); else passes++;
        wait_slot(0);
        checks++; if (i2s_data !== 1'b1) $display("FAIL unmute_lsb: got %b want 1", i2s_data); else passes++;
    endtask

    task automatic test_back_to_back_full();
        logic [15:0] l;
        logic [14:0] r;
        logic [15:0] exp_l [5];
        exp_l[0] = 16'hA002; exp_l[1] = 16'hA003; exp_l[2] = 16'hA004;
        exp_l[3] = 16'hA005; exp_l[4] = 16'hA006;
        do_reset();
        push(16'hA001); push(16'hA002); push(16'hA003); push(16'hA004);
        wait_slot(0);
        checks++; if (fifo_level !== 3'd3) $display("FAIL full_level_after_pop: got %0d want 3", fifo_level); else passes++;
        push(16'hA005);
        checks++; if (fifo_level !== 3'd4) $display("FAIL full_level: got %0d want 4", fifo_level); else passes++;
        wait_pos(255);
        checks++; if (fifo_level !== 3'd4) $display("FAIL full_level_pre: got %0d want 4", fifo_level); else passes++;
        push(16'hA006);
        checks++; if (overflow !== 1'b0) $display("FAIL full_simul_overflow: got %b want 0", overflow); else passes++;
        checks++; if (fifo_level !== 3'd4) $display("FAIL full_simul_level: got %0d want 4", fifo_level); else passes++;
        checks++; if (underrun !== 1'b0) $display("FAIL full_simul_underrun: got %b want 0", underrun); else passes++;
        for (int f = 0; f < 5; f++) begin
            collect_frame(l, r);
            checks++;
            if (l !== exp_l[f]) $display("FAIL full_frame_left %0d: got %h want %h", f, l, exp_l[f]);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_underrun();
        test_overflow();
        test_reset_midframe();
        test_mute();
        test_back_to_back_full();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_audio_i2s_tx

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
Serial audio transmitter that consumes the mixed 16-bit signed sample stream, produced once per 96 kHz sample enable, and drives an I2S DAC. A small sync FIFO absorbs phase difference between the sample strobe and the I2S frame clock. Each mono sample is duplicated onto the left and right channels. The block sits at the top level between the sound mixer output and the board audio pins.

Parameters:
SAMPLE_W, 16, sample width and bits per channel slot; frame = 2*SAMPLE_W bclk.
BCLK_DIV, 4, clk cycles per bclk half-period; must be ≥2. Defaults give 24.576 MHz clk → 3.072 MHz bclk → 96 kHz frame.
FIFO_DEPTH, 4, sample FIFO entries; power of 2.

Ports:
clk  in  1  audio clock; all logic on posedge.
reset_n  in  1  synchronous active-low reset.
sample_valid  in  1  push strobe, one cycle per sample.
sample  in  SAMPLE_W  signed sample, two's complement.
mute  in  1  transmit zeros while still draining the FIFO.
i2s_bclk  out  1  bit clock.
i2s_lrck  out  1  word select; 0 = left, 1 = right.
i2s_data  out  1  serial data, MSB first, changes on bclk falling edge.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
underrun  out  1  one-cycle pulse: frame started with FIFO empty.
overflow  out  1  one-cycle pulse: push dropped because FIFO was full.

Behaviour:
- Reset (reset_n low at posedge), next cycle: i2s_bclk=0, i2s_lrck=0, i2s_data=0, fifo_level=0, underrun=0, overflow=0. Divider, slot counter, shift register and last_sample are all 0. Reset mid-frame aborts the frame immediately; no partial completion.
- Divider: div_cnt runs 0..BCLK_DIV-1. On the wrap, bclk toggles.
- Slot counter: a "falling edge" is the cycle in which bclk toggles 1→0. Slot k (0..2*SAMPLE_W-1) increments on each falling edge and wraps to 0. The first falling edge after reset is slot 0.
- Registered outputs update on the falling-edge cycle:
  - lrck = 0 for slots 0..SAMPLE_W-1 and 1 for slots SAMPLE_W..2*SAMPLE_W-1.
  - slot 0 data = LSB of the previous frame's right word (0 after reset).
  - slots 1..SAMPLE_W = left bits MSB..LSB (standard one-bclk I2S delay).
  - slots SAMPLE_W+1..2*SAMPLE_W-1 = right bits MSB..bit1; right bit0 goes out in the next frame's slot 0.
- Frame load, at the slot-0 falling-edge cycle:
  - FIFO non-empty: pop the head, frame word = {s,s}, last_sample <= s.
  - FIFO empty: frame word = {last_sample,last_sample}, underrun pulses for that cycle.
  - mute=1 sampled in the same cycle: frame word = 0. The pop and last_sample update happen as normal.
- Push: sample_valid with FIFO not full stores the sample. With FIFO full and no pop in that cycle, the sample is dropped and overflow pulses.
- Simultaneous push and pop:
  - FIFO full: both happen, no overflow, level unchanged.
  - FIFO empty: there is no bypass. Underrun is reported, the pushed sample is stored, and level becomes 1.
- fifo_level is registered and reflects completed pushes and pops.
- Latency: a sample pushed into an empty FIFO at least 1 cycle before the slot-0 edge appears as the MSB at slot 1 of that frame.
- The frame period is exactly 4*SAMPLE_W*BCLK_DIV clk cycles (256 at defaults), free-running and independent of sample_valid.

Decomposition:
- Shared package audio_pkg: SAMPLE_W constant, typedef sample_t (signed [SAMPLE_W-1:0]), typedef frame_t (logic [2*SAMPLE_W-1:0]).
- Sub-module sample_fifo: synchronous FIFO with push/pop/full/empty/level, no bypass, write-when-full ignored.
- The top level holds the divider, slot counter, shift register, last_sample and the underrun/overflow pulse logic.

Test Plan:
1. Reset, then push 16'h8001 once before the first slot 0 → slots 1..16 data = 1,0×14,1 with lrck=0; slots 17..31 data = 1,0×14 with lrck=1; next slot 0 data=1; frame period 256 clk; bclk period 8 clk.
2. No pushes after reset → underrun pulses exactly once per 256 clk, at each slot-0 cycle; data all zero. Then push 16'h1234 once → frames carry 16'h1234 on both channels and continue repeating it, with underrun pulsing each subsequent frame.
3. Push 5 samples 16'h0001..16'h0005 back-to-back while no pop occurs → overflow pulses on the 5th push, fifo_level=4; the next four frames carry 1,2,3,4 in order.
4. Assert reset_n low for one cycle at slot 20 → the next cycle shows bclk=lrck=data=0 and fifo_level=0; the new frame starts at slot 0, 8 clk later.
5. With mute=1 and FIFO holding 16'h7FFF → the frame transmits all zeros and fifo_level drops 1→0. Deassert mute → the following frame repeats 16'h7FFF from last_sample and underrun pulses.
6. With the FIFO full, push on the exact slot-0 cycle → no overflow pulse, fifo_level stays 4, and the pushed value appears 4 frames later.
